// File: rtl/fir_sequencer_if.sv
// ----------------------------------------------------------------------------
// fir_sequencer_if
//   Bundles the request/status inputs and the ALU/register-file control
//   outputs of the FIR sequencer.
//
//   Handshake: dr and lc are level signals from the datapath side; the
//   sequencer acts only on their rising edges seen while it is IDLE (EIDLE
//   additionally consumes a dr edge to clear the error). There is no
//   backpressure. modwait high means the sequencer is busy and any new
//   request edge will be dropped, not queued.
//
//   master modport : datapath / request side (drives dr, lc, overflow, alt_sign)
//   slave  modport : the sequencer itself (drives op, addresses and status)
// ----------------------------------------------------------------------------
interface fir_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              dr;        // data-ready request
    logic              lc;        // load-coefficient request
    logic              overflow;  // ALU overflow for the current op
    logic              alt_sign;  // 1: alternate +,-,+,- accumulate signs
    logic [2:0]        op;        // ALU op code
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dest;
    logic              modwait;   // registered busy flag
    logic              err;       // error flag
    logic              cnt_up;    // pulse per accepted sample
    logic              clear;     // pulse at start of a coefficient set
    logic              coef_rdy;  // full coefficient set loaded since reset

    modport master (
        output dr, lc, overflow, alt_sign,
        input  op, src1, src2, dest, modwait, err, cnt_up, clear, coef_rdy
    );

    modport slave (
        input  dr, lc, overflow, alt_sign,
        output op, src1, src2, dest, modwait, err, cnt_up, clear, coef_rdy
    );
endinterface

// File: rtl/fir_sequencer.sv
// ----------------------------------------------------------------------------
// fir_sequencer
//   Control sequencer for an N-tap FIR datapath. Loads coefficients into the
//   register file one at a time, and for each accepted sample: stores it,
//   zeroes the accumulator, shifts the sample line, then runs N
//   multiply/accumulate pairs.
//
//   Register map (N = NUM_TAPS):
//     0          accumulator
//     1..N       sample line, 1 = oldest
//     N+1        sample staging
//     N+2        product temp
//     N+3+j      coefficient j
//
//   Ports:
//     clk        system clock, rising edge
//     n_rst      synchronous active-low reset
//     bus        fir_sequencer_if.slave (requests in, ALU control out)
//     state_dbg  current FSM state encoding, for observation only
// ----------------------------------------------------------------------------
module fir_sequencer #(
    parameter int NUM_TAPS = 4,
    parameter int ADDR_W   = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    fir_sequencer_if.slave   bus,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_C = 3'd1,
        STORE  = 3'd2,
        ZERO   = 3'd3,
        SHIFT  = 3'd4,
        MUL    = 3'd5,
        ACC    = 3'd6,
        EIDLE  = 3'd7
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LDS   = 3'b010;
    localparam logic [2:0] OP_LDC   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    localparam logic [2:0]        K_LAST  = 3'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] A_STAGE = ADDR_W'(NUM_TAPS + 1);
    localparam logic [ADDR_W-1:0] A_PROD  = ADDR_W'(NUM_TAPS + 2);
    localparam logic [ADDR_W-1:0] A_COEF0 = ADDR_W'(NUM_TAPS + 3);
    // Tap k pairs sample k+1 with coefficient N-1-k, i.e. address 2N+2-k.
    localparam logic [ADDR_W-1:0] A_MULC  = ADDR_W'(2 * NUM_TAPS + 2);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TWO   = ADDR_W'(2);

    state_t            state, next_state;
    logic [2:0]        k;
    logic [2:0]        c;
    logic              dr_prev, lc_prev;
    logic              coef_rdy_q, modwait_q;
    logic              dr_edge, lc_edge;
    logic [ADDR_W-1:0] k_a, c_a;

    logic [2:0]        op_c;
    logic [ADDR_W-1:0] src1_c, src2_c, dest_c;
    logic              err_c, cnt_up_c, clear_c;

    assign dr_edge = bus.dr & ~dr_prev;
    assign lc_edge = bus.lc & ~lc_prev;
    assign k_a     = ADDR_W'(k);
    assign c_a     = ADDR_W'(c);

    // State register, counters and registered flags.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            k          <= 3'd0;
            c          <= 3'd0;
            coef_rdy_q <= 1'b0;
            modwait_q  <= 1'b0;
            dr_prev    <= 1'b0;
            lc_prev    <= 1'b0;
        end else begin
            state     <= next_state;
            modwait_q <= (next_state != IDLE) && (next_state != EIDLE);
            dr_prev   <= bus.dr;
            lc_prev   <= bus.lc;
            case (state)
                LOAD_C: begin
                    if (c == K_LAST) begin
                        c          <= 3'd0;
                        coef_rdy_q <= 1'b1;
                    end else begin
                        c <= c + 3'd1;
                    end
                end
                ZERO:  k <= 3'd0;
                SHIFT: k <= (k == K_LAST) ? 3'd0 : k + 3'd1;
                ACC: begin
                    if (!bus.overflow && (k != K_LAST)) k <= k + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and combinational outputs.
    always_comb begin
        next_state = state;
        op_c       = OP_NOP;
        src1_c     = '0;
        src2_c     = '0;
        dest_c     = '0;
        err_c      = 1'b0;
        cnt_up_c   = 1'b0;
        clear_c    = 1'b0;
        case (state)
            IDLE: begin
                // lc wins; a dr edge in the same cycle is lost.
                if (lc_edge)      next_state = LOAD_C;
                else if (dr_edge) next_state = coef_rdy_q ? STORE : EIDLE;
            end
            LOAD_C: begin
                op_c       = OP_LDC;
                dest_c     = A_COEF0 + c_a;
                clear_c    = (c == 3'd0);
                next_state = IDLE;
            end
            STORE: begin
                op_c       = OP_LDS;
                dest_c     = A_STAGE;
                cnt_up_c   = 1'b1;
                // A single-cycle dr pulse is treated as a malformed request.
                next_state = bus.dr ? ZERO : EIDLE;
            end
            ZERO: begin
                op_c       = OP_SUB;
                next_state = SHIFT;
            end
            SHIFT: begin
                op_c       = OP_COPY;
                src1_c     = k_a + A_TWO;
                dest_c     = k_a + A_ONE;
                next_state = (k == K_LAST) ? MUL : SHIFT;
            end
            MUL: begin
                op_c       = OP_MUL;
                src1_c     = k_a + A_ONE;
                src2_c     = A_MULC - k_a;
                dest_c     = A_PROD;
                next_state = ACC;
            end
            ACC: begin
                op_c   = (bus.alt_sign && k[0]) ? OP_SUB : OP_ADD;
                src2_c = A_PROD;
                if (bus.overflow)     next_state = EIDLE;
                else if (k == K_LAST) next_state = IDLE;
                else                  next_state = MUL;
            end
            EIDLE: begin
                err_c = 1'b1;
                if (dr_edge) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Keep the datapath quiet while reset is held, whatever the state.
        if (!n_rst) begin
            op_c     = OP_NOP;
            src1_c   = '0;
            src2_c   = '0;
            dest_c   = '0;
            err_c    = 1'b0;
            cnt_up_c = 1'b0;
            clear_c  = 1'b0;
        end
    end

    assign bus.op       = op_c;
    assign bus.src1     = src1_c;
    assign bus.src2     = src2_c;
    assign bus.dest     = dest_c;
    assign bus.err      = err_c;
    assign bus.cnt_up   = cnt_up_c;
    assign bus.clear    = clear_c;
    assign bus.modwait  = modwait_q;
    assign bus.coef_rdy = coef_rdy_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_fir_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fir_sequencer
//   Directed and randomized checks of fir_sequencer. An N=4 instance gets the
//   full sequence checks against an operation-list model; an N=8, ADDR_W=5
//   instance checks coefficient addressing, latency and the last MUL.
// ----------------------------------------------------------------------------
module tb_fir_sequencer;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int N8  = 8;
    localparam int AW8 = 5;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    fir_sequencer_if #(.ADDR_W(AW))  bus  ();
    fir_sequencer_if #(.ADDR_W(AW8)) bus8 ();
    logic [2:0] st_dbg, st8_dbg;

    fir_sequencer #(.NUM_TAPS(N), .ADDR_W(AW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus.slave),
        .state_dbg (st_dbg)
    );

    fir_sequencer #(.NUM_TAPS(N8), .ADDR_W(AW8)) dut8 (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus8.slave),
        .state_dbg (st8_dbg)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [2:0] op;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] d;
        logic       cu;
        logic       ovf;   // drive overflow during this cycle
        logic       lcp;   // drive an lc pulse during this cycle
    } step_t;

    step_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    c_model = 0;
    bit    rdy_model = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic step_t mk(input int op, input int s1, input int s2, input int d,
                                 input bit cu, input bit ovf, input bit lcp);
        step_t s;
        s.op  = 3'(op);
        s.s1  = 8'(s1);
        s.s2  = 8'(s2);
        s.d   = 8'(d);
        s.cu  = cu;
        s.ovf = ovf;
        s.lcp = lcp;
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One lc pulse from IDLE on the N=4 instance.
    task automatic load_coef();
        bus.lc = 1'b1;
        step();
        chk("lc_op",    bus.op,    3'b011);
        chk("lc_dest",  bus.dest,  N + 3 + c_model);
        chk("lc_clear", bus.clear, (c_model == 0));
        chk("lc_busy",  bus.modwait, 1);
        c_model = (c_model + 1) % N;
        if (c_model == 0) rdy_model = 1'b1;
        bus.lc = 1'b0;
        step();
        chk("lc_rdy",     bus.coef_rdy, rdy_model);
        chk("lc_idle_op", bus.op,       0);
    endtask

    // Operation list a sample request should produce, built from the
    // register map: store, clear acc, shift line, then N mul/acc pairs.
    task automatic build_trace(input bit hold, input bit alt, input int ovf_acc,
                               input int ovf_mul, input int lc_at, output bit ends_err);
        exp_q.delete();
        exp_q.push_back(mk(3'b010, 0, 0, N + 1, 1, 0, 0));
        ends_err = !hold;
        if (hold) begin
            exp_q.push_back(mk(3'b101, 0, 0, 0, 0, 0, 0));
            for (int i = 0; i < N; i++)
                exp_q.push_back(mk(3'b001, i + 2, 0, i + 1, 0, 0, 0));
            for (int i = 0; i < N; i++) begin
                exp_q.push_back(mk(3'b110, i + 1, N + 3 + (N - 1 - i), N + 2, 0,
                                   (i == ovf_mul), (i == lc_at)));
                exp_q.push_back(mk((alt && (i % 2 == 1)) ? 3'b101 : 3'b100, 0, N + 2, 0, 0,
                                   (i == ovf_acc), 0));
                if (i == ovf_acc) begin
                    ends_err = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic run_sample(input bit hold, input bit alt, input int ovf_acc,
                              input int ovf_mul, input int lc_at);
        bit    ends_err;
        step_t e;
        build_trace(hold, alt, ovf_acc, ovf_mul, lc_at, ends_err);
        bus.alt_sign = alt;
        bus.dr       = 1'b1;
        step();
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            chk("seq_op",     bus.op,      e.op);
            chk("seq_src1",   bus.src1,    e.s1);
            chk("seq_src2",   bus.src2,    e.s2);
            chk("seq_dest",   bus.dest,    e.d);
            chk("seq_cnt_up", bus.cnt_up,  e.cu);
            chk("seq_busy",   bus.modwait, 1);
            chk("seq_err",    bus.err,     0);
            bus.dr       = (i == 0) ? hold : 1'b0;
            bus.overflow = e.ovf;
            bus.lc       = e.lcp;
            step();
        end
        bus.overflow = 1'b0;
        bus.lc       = 1'b0;
        chk("end_busy", bus.modwait, 0);
        chk("end_err",  bus.err,     ends_err);
        chk("end_op",   bus.op,      0);
        chk("end_rdy",  bus.coef_rdy, rdy_model);
        if (ends_err) begin
            bus.dr = 1'b1;
            step();
            chk("recover_err", bus.err, 0);
            bus.dr = 1'b0;
            step();
            chk("recover_idle_busy", bus.modwait, 0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int busy8;
        int last_s1, last_s2;

        bus.dr = 1'b0;  bus.lc = 1'b0;  bus.overflow = 1'b0;  bus.alt_sign = 1'b0;
        bus8.dr = 1'b0; bus8.lc = 1'b0; bus8.overflow = 1'b0; bus8.alt_sign = 1'b0;

        // Reset state.
        n_rst = 1'b0;
        step();
        step();
        chk("rst_op",      bus.op,       0);
        chk("rst_src1",    bus.src1,     0);
        chk("rst_src2",    bus.src2,     0);
        chk("rst_dest",    bus.dest,     0);
        chk("rst_err",     bus.err,      0);
        chk("rst_cnt_up",  bus.cnt_up,   0);
        chk("rst_clear",   bus.clear,    0);
        chk("rst_modwait", bus.modwait,  0);
        chk("rst_coefrdy", bus.coef_rdy, 0);
        n_rst = 1'b1;
        step();

        // dr before any coefficient -> EIDLE; lc ignored there; dr edge leaves.
        bus.dr = 1'b1;
        step();
        chk("nocoef_err",  bus.err,     1);
        chk("nocoef_op",   bus.op,      0);
        chk("nocoef_busy", bus.modwait, 0);
        bus.dr = 1'b0;
        bus.lc = 1'b1;
        step();
        chk("eidle_lc_err", bus.err, 1);
        bus.lc = 1'b0;
        step();
        bus.dr = 1'b1;
        step();
        chk("eidle_exit_err", bus.err, 0);
        bus.dr = 1'b0;
        step();

        // Four coefficients.
        for (int j = 0; j < N; j++) load_coef();

        // Full sample, alternating signs.
        run_sample(1'b1, 1'b1, -1, -1, -1);
        // Single-cycle dr pulse.
        run_sample(1'b0, 1'b0, -1, -1, -1);
        // Overflow in second ACC, overflow during first MUL ignored.
        run_sample(1'b1, 1'b0, 1, 0, -1);

        // lc and dr edges together in IDLE -> coefficient load only.
        bus.lc = 1'b1;
        bus.dr = 1'b1;
        step();
        chk("both_op",     bus.op,     3'b011);
        chk("both_dest",   bus.dest,   N + 3 + c_model);
        chk("both_cnt_up", bus.cnt_up, 0);
        c_model = (c_model + 1) % N;
        bus.lc = 1'b0;
        bus.dr = 1'b0;
        step();
        chk("both_idle_op",   bus.op,      0);
        chk("both_idle_busy", bus.modwait, 0);
        chk("both_idle_err",  bus.err,     0);
        while (c_model != 0) load_coef();

        // Randomized samples.
        for (int r = 0; r < 8; r++) begin
            bit hold, alt;
            int oa, om, la;
            hold = ($urandom_range(0, 3) != 0);
            alt  = 1'($urandom_range(0, 1));
            oa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
            om   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
            la   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
            run_sample(hold, alt, oa, om, la);
        end

        // Reset in the middle of SHIFT.
        bus.dr = 1'b1;
        step();
        step();
        step();
        chk("pre_rst_op", bus.op, 3'b001);
        n_rst = 1'b0;
        step();
        chk("midrst_op",      bus.op,       0);
        chk("midrst_busy",    bus.modwait,  0);
        chk("midrst_coefrdy", bus.coef_rdy, 0);
        chk("midrst_err",     bus.err,      0);
        n_rst  = 1'b1;
        bus.dr = 1'b0;
        c_model   = 0;
        rdy_model = 1'b0;
        step();
        // Coefficients are gone, so a sample is refused again.
        bus.dr = 1'b1;
        step();
        chk("postrst_err", bus.err, 1);
        bus.dr = 1'b0;
        step();
        bus.dr = 1'b1;
        step();
        bus.dr = 1'b0;
        step();
        load_coef();
        chk("postrst_partial_rdy", bus.coef_rdy, 0);

        // N=8 instance: coefficient addresses, latency, last MUL.
        for (int j = 0; j < N8; j++) begin
            bus8.lc = 1'b1;
            step();
            chk("n8_lc_dest", bus8.dest, N8 + 3 + j);
            bus8.lc = 1'b0;
            step();
        end
        chk("n8_coefrdy", bus8.coef_rdy, 1);
        bus8.dr = 1'b1;
        step();
        busy8   = 0;
        last_s1 = 0;
        last_s2 = 0;
        while (bus8.modwait === 1'b1 && busy8 < 60) begin
            busy8++;
            if (bus8.op === 3'b110) begin
                last_s1 = int'(bus8.src1);
                last_s2 = int'(bus8.src2);
            end
            bus8.dr = (busy8 == 1);
            step();
        end
        bus8.dr = 1'b0;
        chk("n8_busy_cycles", busy8,   26);
        chk("n8_last_src1",   last_s1, 8);
        chk("n8_last_src2",   last_s2, 11);
        chk("n8_end_err",     bus8.err, 0);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
